// File: rtl/traffic_pkg.sv
// Shared types and lamp encodings for the intersection phase scheduler.
// Lamp vectors are {red, yellow, green}.
package traffic_pkg;

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    EW_GREEN  = 3'd2,
    EW_YELLOW = 3'd3,
    ALL_RED   = 3'd4,
    PED_WALK  = 3'd5,
    PED_CLEAR = 3'd6
  } state_e;

  typedef enum logic {
    ROAD_NS = 1'b0,
    ROAD_EW = 1'b1
  } road_e;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  typedef struct packed {
    logic [2:0] ns;
    logic [2:0] ew;
    logic       walk;
  } lamps_t;

  // Moore lamp decode; any unknown state code shows all-red.
  function automatic lamps_t decode_lamps(input state_e s);
    lamps_t l;
    l.ns   = LAMP_RED;
    l.ew   = LAMP_RED;
    l.walk = 1'b0;
    case (s)
      NS_GREEN:  l.ns   = LAMP_GRN;
      NS_YELLOW: l.ns   = LAMP_YEL;
      EW_GREEN:  l.ew   = LAMP_GRN;
      EW_YELLOW: l.ew   = LAMP_YEL;
      PED_WALK:  l.walk = 1'b1;
      default:   l.walk = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Dwell counter: synchronous clear, optional saturation, terminal compare.
module phase_timer #(
  parameter int unsigned CW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_clear,
  input  logic          i_sat_en,
  input  logic [CW-1:0] i_sat_val,
  input  logic [CW-1:0] i_term_val,
  output logic [CW-1:0] o_count,
  output logic          o_term_c
);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (!(i_sat_en && (r_count >= i_sat_val))) begin
      r_count <= r_count + CW'(1);
    end
  end

  assign o_count  = r_count;
  assign o_term_c = (r_count == i_term_val);

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Actuated two-road intersection scheduler with a latched pedestrian phase.
// Green is held while uncontested; yellow and all-red clear every change of right-of-way.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int unsigned GREEN_MIN = 4,
  parameter int unsigned GREEN_MAX = 12,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 5,
  parameter int unsigned CW        = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_ns_req,
  input  logic       i_ew_req,
  input  logic       i_ped_req,
  output logic [2:0] o_ns_light,
  output logic [2:0] o_ew_light,
  output logic       o_walk,
  output logic       o_ped_pending,
  output logic [2:0] o_phase
);

  localparam logic [CW-1:0] GMIN_LAST   = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_LAST   = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YEL_LAST    = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_T - 1);

  state_e        r_state;
  state_e        w_state_nxt;
  state_e        w_other_green;
  road_e         r_last_road;
  logic          r_ped_pending;
  logic [2:0]    r_ns_light;
  logic [2:0]    r_ew_light;
  logic          r_walk;
  lamps_t        w_lamps_nxt;
  logic [CW-1:0] w_count;
  logic [CW-1:0] w_term_val;
  logic          w_term;
  logic          w_green;
  logic          w_clear;
  logic          w_min_met;
  logic          w_ns_exit;
  logic          w_ew_exit;

  assign w_green       = (r_state == NS_GREEN) || (r_state == EW_GREEN);
  assign w_min_met     = (w_count >= GMIN_LAST);
  assign w_other_green = (r_last_road == ROAD_EW) ? NS_GREEN : EW_GREEN;

  // In green the terminal compare flags the GREEN_MAX cap reached.
  assign w_ns_exit = w_min_met && (i_ew_req || r_ped_pending) && (!i_ns_req || w_term);
  assign w_ew_exit = w_min_met && (i_ns_req || r_ped_pending) && (!i_ew_req || w_term);

  always_comb begin
    w_term_val = ALLRED_LAST;
    case (r_state)
      NS_GREEN, EW_GREEN:   w_term_val = GMAX_LAST;
      NS_YELLOW, EW_YELLOW: w_term_val = YEL_LAST;
      PED_WALK:             w_term_val = WALK_LAST;
      default:              w_term_val = ALLRED_LAST;
    endcase
  end

  phase_timer #(
    .CW(CW)
  ) u_timer (
    .clk       (clk),
    .rst       (rst),
    .i_clear   (w_clear),
    .i_sat_en  (w_green),
    .i_sat_val (GMAX_LAST),
    .i_term_val(w_term_val),
    .o_count   (w_count),
    .o_term_c  (w_term)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      NS_GREEN:  if (w_ns_exit) w_state_nxt = NS_YELLOW;
      NS_YELLOW: if (w_term)    w_state_nxt = ALL_RED;
      EW_GREEN:  if (w_ew_exit) w_state_nxt = EW_YELLOW;
      EW_YELLOW: if (w_term)    w_state_nxt = ALL_RED;
      ALL_RED:   if (w_term)    w_state_nxt = r_ped_pending ? PED_WALK : w_other_green;
      PED_WALK:  if (w_term)    w_state_nxt = PED_CLEAR;
      PED_CLEAR: if (w_term)    w_state_nxt = w_other_green;
      default:                  w_state_nxt = ALL_RED;
    endcase
  end

  assign w_clear     = (w_state_nxt != r_state);
  assign w_lamps_nxt = decode_lamps(w_state_nxt);

  // Lamps are registered from the next state so they always match r_state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= ALL_RED;
      r_last_road   <= ROAD_EW;
      r_ped_pending <= 1'b0;
      r_ns_light    <= LAMP_RED;
      r_ew_light    <= LAMP_RED;
      r_walk        <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_ped_pending <= (r_ped_pending | i_ped_req) & (r_state != PED_WALK);
      if ((r_state == NS_YELLOW) && w_term) begin
        r_last_road <= ROAD_NS;
      end else if ((r_state == EW_YELLOW) && w_term) begin
        r_last_road <= ROAD_EW;
      end
      r_ns_light    <= w_lamps_nxt.ns;
      r_ew_light    <= w_lamps_nxt.ew;
      r_walk        <= w_lamps_nxt.walk;
    end
  end

  assign o_ns_light    = r_ns_light;
  assign o_ew_light    = r_ew_light;
  assign o_walk        = r_walk;
  assign o_ped_pending = r_ped_pending;
  assign o_phase       = r_state;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench: per-cycle expected phases are queued per scenario, then
// popped and compared against the lamps, walk, pending flag and phase code.
module tb_intersection_phase_scheduler;
  import traffic_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       ns_req;
  logic       ew_req;
  logic       ped_req;
  logic [2:0] ns_light;
  logic [2:0] ew_light;
  logic       walk;
  logic       ped_pending;
  logic [2:0] phase;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct packed {
    state_e ph;
    logic   pp;
  } exp_t;

  exp_t q[$];

  intersection_phase_scheduler dut (
    .clk          (clk),
    .rst          (rst),
    .i_ns_req     (ns_req),
    .i_ew_req     (ew_req),
    .i_ped_req    (ped_req),
    .o_ns_light   (ns_light),
    .o_ew_light   (ew_light),
    .o_walk       (walk),
    .o_ped_pending(ped_pending),
    .o_phase      (phase)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] exp_ns(input state_e s);
    if (s == NS_GREEN)  return 3'b001;
    if (s == NS_YELLOW) return 3'b010;
    return 3'b100;
  endfunction

  function automatic logic [2:0] exp_ew(input state_e s);
    if (s == EW_GREEN)  return 3'b001;
    if (s == EW_YELLOW) return 3'b010;
    return 3'b100;
  endfunction

  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, expv);
    end
  endtask

  task automatic push(input state_e p_ph, input logic p_pp, input int n);
    exp_t e;
    e.ph = p_ph;
    e.pp = p_pp;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  task automatic run_q();
    exp_t e;
    logic both_go;
    while (q.size() > 0) begin
      e = q.pop_front();
      both_go = (ns_light != 3'b100) && (ew_light != 3'b100);
      chk("ns_light", ns_light, exp_ns(e.ph));
      chk("ew_light", ew_light, exp_ew(e.ph));
      chk("walk", {2'b00, walk}, {2'b00, (e.ph == PED_WALK)});
      chk("ped_pending", {2'b00, ped_pending}, {2'b00, e.pp});
      chk("phase", phase, e.ph);
      chk("lamp_conflict", {2'b00, both_go}, 3'b000);
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Assert reset mid-cycle, check the asynchronous response, then release.
  task automatic do_reset(input logic ns, input logic ew);
    rst     = 1'b1;
    ped_req = 1'b0;
    #1;
    chk("rst_ns_light", ns_light, 3'b100);
    chk("rst_ew_light", ew_light, 3'b100);
    chk("rst_walk", {2'b00, walk}, 3'b000);
    chk("rst_ped_pending", {2'b00, ped_pending}, 3'b000);
    chk("rst_phase", phase, ALL_RED);
    ns_req = ns;
    ew_req = ew;
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  initial begin
    rst     = 1'b1;
    ns_req  = 1'b0;
    ew_req  = 1'b0;
    ped_req = 1'b0;
    @(posedge clk);
    #1;

    // Idle: NS takes the first green and rests there, then a one-cycle EW pulse.
    do_reset(1'b0, 1'b0);
    push(ALL_RED, 1'b0, 1);
    push(NS_GREEN, 1'b0, 50);
    run_q();
    ew_req = 1'b1;
    push(NS_GREEN, 1'b0, 1);
    run_q();
    ew_req = 1'b0;
    push(NS_YELLOW, 1'b0, 3);
    push(ALL_RED, 1'b0, 1);
    push(EW_GREEN, 1'b0, 6);
    run_q();

    // EW demand only: NS gets exactly the minimum green.
    do_reset(1'b0, 1'b1);
    push(ALL_RED, 1'b0, 1);
    push(NS_GREEN, 1'b0, 4);
    push(NS_YELLOW, 1'b0, 3);
    push(ALL_RED, 1'b0, 1);
    push(EW_GREEN, 1'b0, 8);
    run_q();

    // Both roads saturated: GREEN_MAX each, 32-cycle period.
    do_reset(1'b1, 1'b1);
    push(ALL_RED, 1'b0, 1);
    for (int p = 0; p < 2; p++) begin
      push(NS_GREEN, 1'b0, 12);
      push(NS_YELLOW, 1'b0, 3);
      push(ALL_RED, 1'b0, 1);
      push(EW_GREEN, 1'b0, 12);
      push(EW_YELLOW, 1'b0, 3);
      push(ALL_RED, 1'b0, 1);
    end
    push(NS_GREEN, 1'b0, 2);
    run_q();

    // Pedestrian pulse at NS timer=1; a press during the walk is absorbed.
    do_reset(1'b0, 1'b0);
    push(ALL_RED, 1'b0, 1);
    push(NS_GREEN, 1'b0, 1);
    run_q();
    ped_req = 1'b1;
    push(NS_GREEN, 1'b0, 1);
    run_q();
    ped_req = 1'b0;
    push(NS_GREEN, 1'b1, 2);
    push(NS_YELLOW, 1'b1, 3);
    push(ALL_RED, 1'b1, 1);
    push(PED_WALK, 1'b1, 1);
    push(PED_WALK, 1'b0, 1);
    run_q();
    ped_req = 1'b1;
    push(PED_WALK, 1'b0, 1);
    run_q();
    ped_req = 1'b0;
    push(PED_WALK, 1'b0, 2);
    push(PED_CLEAR, 1'b0, 1);
    push(EW_GREEN, 1'b0, 5);
    run_q();

    // Reset during EW yellow with a pedestrian pending.
    do_reset(1'b0, 1'b1);
    push(ALL_RED, 1'b0, 1);
    push(NS_GREEN, 1'b0, 4);
    push(NS_YELLOW, 1'b0, 3);
    push(ALL_RED, 1'b0, 1);
    run_q();
    ew_req  = 1'b0;
    ped_req = 1'b1;
    push(EW_GREEN, 1'b0, 1);
    run_q();
    ped_req = 1'b0;
    push(EW_GREEN, 1'b1, 3);
    push(EW_YELLOW, 1'b1, 1);
    run_q();
    do_reset(1'b0, 1'b0);
    push(ALL_RED, 1'b0, 1);
    push(NS_GREEN, 1'b0, 3);
    run_q();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
